// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer: packs a byte stream into padded, length-terminated 512-bit SHA-256 blocks emitted as 16 words
module sha256_msg_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_last,
    input  logic                  core_ready,
    output logic                  in_ready,
    output logic                  MP_dv,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  block_last,
    output logic                  msg_done
);
    typedef enum logic [2:0] {S_COLLECT, S_PAD, S_LEN, S_WAIT, S_EMIT} state_t;
    state_t state, state_d;
    logic [DATA_WIDTH-1:0] mem [16];
    logic [DATA_WIDTH-1:0] hold;
    logic [LEN_WIDTH-1:0]  len;
    logic [63:0]           len64;
    logic [5:0]            bidx;
    logic [3:0]            wcnt;
    logic [7:0]            wr_byte;
    logic                  final_q, pad_pending, len_pending, pad_80;
    logic                  wr_en, full, emit_end;

    assign len64       = 64'(len);
    assign full        = bidx == 6'd63;
    assign emit_end    = state == S_EMIT && wcnt == 4'd15;
    assign wr_en       = (state == S_COLLECT && rx_dv) || state == S_PAD;
    assign wr_byte     = state == S_PAD ? (pad_80 ? 8'h80 : 8'h00) : rx_byte;
    assign in_ready    = state == S_COLLECT;
    assign MP_dv       = state == S_EMIT;
    assign message_out = MP_dv ? mem[wcnt] : hold;
    assign block_last  = emit_end && final_q;

    always_ff @(posedge clk)
        state <= rst ? S_COLLECT : state_d;

    always_comb begin
        state_d = state;
        case (state)
            S_COLLECT: state_d = !rx_dv ? S_COLLECT : full ? S_WAIT : rx_last ? S_PAD : S_COLLECT;
            S_PAD:     state_d = bidx == 6'd55 ? S_LEN : full ? S_WAIT : S_PAD;
            S_LEN:     state_d = S_WAIT;
            S_WAIT:    state_d = core_ready ? S_EMIT : S_WAIT;
            S_EMIT:    state_d = !emit_end ? S_EMIT :
                                 (!final_q && (pad_pending || len_pending)) ? S_PAD : S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx        <= '0;
            wcnt        <= '0;
            len         <= '0;
            hold        <= '0;
            final_q     <= 1'b0;
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
            pad_80      <= 1'b0;
            msg_done    <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            msg_done <= emit_end && final_q;
            if (wr_en) begin
                mem[bidx[5:2]][{~bidx[1:0], 3'b000} +: 8] <= wr_byte;
                bidx <= bidx + 6'd1;
            end
            if (state == S_COLLECT && rx_dv) begin
                len <= len + LEN_WIDTH'(8);
                if (rx_last) begin
                    pad_80      <= 1'b1;
                    pad_pending <= full;
                end
            end
            // a pad run that reaches byte 63 leaves no room for the length field
            if (state == S_PAD) begin
                pad_80 <= 1'b0;
                if (full) len_pending <= 1'b1;
            end
            if (state == S_LEN) begin
                mem[14] <= len64[63:32];
                mem[15] <= len64[31:0];
                final_q <= 1'b1;
            end
            if (MP_dv) begin
                hold <= mem[wcnt];
                wcnt <= wcnt + 4'd1;
            end
            if (emit_end) begin
                for (int i = 0; i < 16; i++) mem[i] <= '0;
                bidx <= '0;
                if (final_q) begin
                    len         <= '0;
                    final_q     <= 1'b0;
                    pad_pending <= 1'b0;
                    len_pending <= 1'b0;
                    pad_80      <= 1'b0;
                end else if (pad_pending) begin
                    pad_pending <= 1'b0;
                    pad_80      <= 1'b1;
                end else begin
                    len_pending <= 1'b0;
                    pad_80      <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sha256_msg_packer.sv
// tb_sha256_msg_packer: randomized and directed checks of the packer against a byte-level SHA-256 padding model
module tb_sha256_msg_packer;
    logic        clk = 1'b0;
    logic        rst, rx_dv, rx_last, core_ready;
    logic [7:0]  rx_byte;
    logic        in_ready, MP_dv, block_last, msg_done;
    logic [31:0] message_out;
    int          checks = 0, errors = 0, cyc = 0, done_n = 0, done_c = 0;
    logic [31:0] got_w[$];
    bit          got_bl[$];
    int          got_c[$];

    always #5 clk = ~clk;

    sha256_msg_packer dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .rx_last(rx_last),
        .core_ready(core_ready), .in_ready(in_ready), .MP_dv(MP_dv),
        .message_out(message_out), .block_last(block_last), .msg_done(msg_done)
    );

    always @(posedge clk) cyc++;

    always @(posedge clk)
        if (!rst) assert (!(rx_dv && !in_ready)) else $error("rx_dv driven while in_ready low");

    always @(negedge clk) begin
        if (MP_dv) begin
            got_w.push_back(message_out);
            got_bl.push_back(block_last);
            got_c.push_back(cyc);
        end else if (block_last) begin
            errors++;
            $display("FAIL block_last_idle: block_last=1 while MP_dv=0 at cycle %0d", cyc);
        end
        if (msg_done) begin
            done_n++;
            done_c = cyc;
        end
    end

    function automatic void model(input logic [7:0] b[$], output logic [31:0] w[$], output bit bl[$]);
        logic [7:0]  p[$];
        logic [63:0] bits;
        p = b;
        bits = 64'(b.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        w.delete();
        bl.delete();
        for (int i = 0; i < p.size() / 4; i++) begin
            w.push_back({p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
            bl.push_back(i == p.size() / 4 - 1);
        end
    endfunction

    task automatic clear_cap();
        got_w.delete();
        got_bl.delete();
        got_c.delete();
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            int t = 0;
            while (!in_ready && t < 5000) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=0 still after %0d cycles, required 1", t);
                return;
            end
            rx_dv = 1'b1;
            rx_byte = b[i];
            rx_last = (i == b.size() - 1);
            @(posedge clk); #1;
            rx_dv = 1'b0;
            rx_last = 1'b0;
        end
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_n == prev && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (done_n == prev) begin
            errors++;
            $display("FAIL done_timeout: msg_done count %0d, required %0d", done_n, prev + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_dv = 1'b0; rx_last = 1'b0; rx_byte = 8'h00; core_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, MP_dv, block_last, msg_done} !== 4'b1000 || message_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b MP_dv=%b block_last=%b msg_done=%b message_out=%h, required 1 0 0 0 00000000",
                     in_ready, MP_dv, block_last, msg_done, message_out);
        end
    endtask

    task automatic test_abc();
        logic [7:0]  b[$] = '{8'h61, 8'h62, 8'h63};
        logic [31:0] e;
        int prev;
        clear_cap();
        prev = done_n;
        send_bytes(b);
        wait_done(prev);
        checks++;
        if (got_w.size() != 16) begin
            errors++;
            $display("FAIL abc_count: got %0d words, required 16", got_w.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = i == 0 ? 32'h61626380 : i == 15 ? 32'h00000018 : 32'h0;
                checks++;
                if (got_w[i] !== e || got_bl[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL abc_w%0d: got %h bl=%b, required %h bl=%b", i, got_w[i], got_bl[i], e, i == 15);
                end
            end
            checks++;
            if (got_c[15] - got_c[0] != 15 || done_c != got_c[15] + 1) begin
                errors++;
                $display("FAIL abc_timing: span %0d done at +%0d, required 15 and +1", got_c[15] - got_c[0], done_c - got_c[15]);
            end
        end
    endtask

    task automatic test_lengths();
        int lens[$] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 128};
        repeat (6) lens.push_back($urandom_range(1, 200));
        foreach (lens[n]) begin
            logic [7:0]  b[$];
            logic [31:0] ew[$];
            bit          ebl[$];
            int prev;
            for (int i = 0; i < lens[n]; i++) b.push_back(lens[n] == 55 ? 8'h00 : 8'($urandom));
            model(b, ew, ebl);
            clear_cap();
            prev = done_n;
            send_bytes(b);
            wait_done(prev);
            checks++;
            if (got_w.size() != ew.size()) begin
                errors++;
                $display("FAIL len%0d_count: got %0d words, required %0d", lens[n], got_w.size(), ew.size());
                continue;
            end
            for (int i = 0; i < ew.size(); i++) begin
                checks++;
                if (got_w[i] !== ew[i] || got_bl[i] !== ebl[i]) begin
                    errors++;
                    $display("FAIL len%0d_w%0d: got %h bl=%b, required %h bl=%b", lens[n], i, got_w[i], got_bl[i], ew[i], ebl[i]);
                end
                if (i % 16 != 0 && got_c[i] != got_c[i-1] + 1) begin
                    errors++;
                    $display("FAIL len%0d_gap%0d: word at cycle %0d, required %0d", lens[n], i, got_c[i], got_c[i-1] + 1);
                end
            end
            checks++;
            if (done_c != got_c[ew.size()-1] + 1) begin
                errors++;
                $display("FAIL len%0d_done: msg_done at cycle %0d, required %0d", lens[n], done_c, got_c[ew.size()-1] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  b[$];
        logic [31:0] ew[$];
        bit          ebl[$];
        int prev;
        for (int i = 0; i < 70; i++) b.push_back(8'($urandom));
        model(b, ew, ebl);
        clear_cap();
        prev = done_n;
        core_ready = 1'b0;
        fork
            send_bytes(b);
            begin
                int t = 0;
                while (in_ready && t < 500) begin
                    @(posedge clk); #1;
                    t++;
                end
                repeat (50) begin
                    @(negedge clk);
                    checks++;
                    if (MP_dv !== 1'b0 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall: MP_dv=%b in_ready=%b, required 0 0", MP_dv, in_ready);
                    end
                end
                @(posedge clk); #1;
                core_ready = 1'b1;
            end
        join
        wait_done(prev);
        checks++;
        if (got_w.size() != ew.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d words, required %0d", got_w.size(), ew.size());
        end else begin
            for (int i = 0; i < ew.size(); i++) begin
                checks++;
                if (got_w[i] !== ew[i] || got_bl[i] !== ebl[i] || (i % 16 != 0 && got_c[i] != got_c[i-1] + 1)) begin
                    errors++;
                    $display("FAIL stall_w%0d: got %h bl=%b cyc=%0d, required %h bl=%b contiguous", i, got_w[i], got_bl[i], got_c[i], ew[i], ebl[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$] = '{8'h61, 8'h62, 8'h63};
        int prev, t = 0;
        clear_cap();
        prev = done_n;
        send_bytes(b);
        while (got_w.size() < 7 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (MP_dv !== 1'b0 || in_ready !== 1'b1 || message_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: MP_dv=%b in_ready=%b message_out=%h, required 0 1 00000000", MP_dv, in_ready, message_out);
        end
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (MP_dv !== 1'b0 || done_n != prev) begin
                errors++;
                $display("FAIL mid_quiet: MP_dv=%b msg_done count=%0d, required 0 and %0d", MP_dv, done_n, prev);
            end
        end
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_lengths();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
